// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master bit/byte sequencer:
// command encoding and controller state codes.
package i2c_pkg;

  typedef enum logic [1:0] {
    I2C_CMD_START = 2'd0,
    I2C_CMD_STOP  = 2'd1,
    I2C_CMD_WRITE = 2'd2,
    I2C_CMD_READ  = 2'd3
  } i2c_cmd_e;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_START_A = 4'd1;
  localparam logic [3:0] ST_START_B = 4'd2;
  localparam logic [3:0] ST_RS_A    = 4'd3;
  localparam logic [3:0] ST_RS_B    = 4'd4;
  localparam logic [3:0] ST_RS_C    = 4'd5;
  localparam logic [3:0] ST_RS_D    = 4'd6;
  localparam logic [3:0] ST_HOLD    = 4'd7;
  localparam logic [3:0] ST_BIT_LO  = 4'd8;
  localparam logic [3:0] ST_BIT_HI  = 4'd9;
  localparam logic [3:0] ST_STOP_A  = 4'd10;
  localparam logic [3:0] ST_STOP_B  = 4'd11;

endpackage

// File: rtl/i2c_master_ctrl.sv
// Command-driven I2C master sequencer: START, repeated START, STOP,
// byte WRITE and byte READ, paced by the half-period strobe scl_tick.
// Optional build macro I2C_CLK_STRETCH_EN: while SCL is released, a tick
// is honoured only once the pad reads SCL high (slave clock stretching).
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_tick,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_ack,
  output logic [BYTE_W-1:0] rd_data,
  output logic              ack_rcvd,
  output logic              done,
  output logic              err,
  output logic              bus_owned,
  output logic              scl_oe,
  output logic              sda_oe,
  input  logic              scl_in,
  input  logic              sda_in
);

  localparam int CNT_W = $clog2(BYTE_W + 1);

  logic [3:0]        state;
  logic [BYTE_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              is_rd;
  logic              ack_bit;
  logic              sda_upd;
  logic              tick_ok;
  logic              accept;
  i2c_cmd_e          cmd_e;

  // SDA level for the cell being entered; cnt==0 marks the ACK cell
  function automatic logic cell_sda(input logic rd, input logic ack,
                                    input logic [CNT_W-1:0] c,
                                    input logic msb);
    if (c == '0) cell_sda = rd ? ack : 1'b0;
    else         cell_sda = rd ? 1'b0 : ~msb;
  endfunction

`ifdef I2C_CLK_STRETCH_EN
  // Released SCL must actually read high before the next tick counts
  assign tick_ok = scl_tick & (scl_oe | scl_in);
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign tick_ok       = scl_tick;
`endif

  assign cmd_e     = i2c_cmd_e'(cmd);
  assign cmd_ready = (state == ST_IDLE) || (state == ST_HOLD);
  assign accept    = cmd_valid & cmd_ready;

  // Main sequencer: pin drive, results and completion pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      bus_owned <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_data   <= '0;
      ack_rcvd  <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      is_rd     <= 1'b0;
      ack_bit   <= 1'b0;
      sda_upd   <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      sda_upd <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (cmd_e == I2C_CMD_START) begin
              state <= ST_START_A;
            end else begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // Release SDA one clk after the final ACK-cell fall
          if (sda_upd) sda_oe <= 1'b0;
          if (accept) begin
            case (cmd_e)
              I2C_CMD_START: state <= ST_RS_A;
              I2C_CMD_STOP: begin
                sda_oe <= 1'b1;
                state  <= ST_STOP_A;
              end
              default: begin
                is_rd   <= (cmd_e == I2C_CMD_READ);
                ack_bit <= rd_ack;
                cnt     <= CNT_W'(BYTE_W);
                shreg   <= (cmd_e == I2C_CMD_READ) ? '0 : wr_data;
                sda_oe  <= (cmd_e == I2C_CMD_READ) ? 1'b0 : ~wr_data[BYTE_W-1];
                state   <= ST_BIT_LO;
              end
            endcase
          end
        end
        ST_START_A: if (tick_ok) begin
          sda_oe <= 1'b1;
          state  <= ST_START_B;
        end
        ST_START_B: if (tick_ok) begin
          scl_oe    <= 1'b1;
          bus_owned <= 1'b1;
          done      <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_RS_A: if (tick_ok) begin
          sda_oe <= 1'b0;
          state  <= ST_RS_B;
        end
        ST_RS_B: if (tick_ok) begin
          scl_oe <= 1'b0;
          state  <= ST_RS_C;
        end
        ST_RS_C: if (tick_ok) begin
          sda_oe <= 1'b1;
          state  <= ST_RS_D;
        end
        ST_RS_D: if (tick_ok) begin
          scl_oe <= 1'b1;
          done   <= 1'b1;
          state  <= ST_HOLD;
        end
        ST_STOP_A: if (tick_ok) begin
          scl_oe <= 1'b0;
          state  <= ST_STOP_B;
        end
        ST_STOP_B: if (tick_ok) begin
          sda_oe    <= 1'b0;
          bus_owned <= 1'b0;
          done      <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_BIT_LO: begin
          // SDA for the new cell goes out one clk after SCL fell
          if (sda_upd) sda_oe <= cell_sda(is_rd, ack_bit, cnt, shreg[BYTE_W-1]);
          if (tick_ok) begin
            scl_oe <= 1'b0;
            state  <= ST_BIT_HI;
          end
        end
        ST_BIT_HI: if (tick_ok) begin
          scl_oe  <= 1'b1;
          sda_upd <= 1'b1;
          if (cnt == '0) begin
            if (!is_rd) ack_rcvd <= ~sda_in;
            done  <= 1'b1;
            state <= ST_HOLD;
          end else begin
            shreg <= {shreg[BYTE_W-2:0], (is_rd ? sda_in : 1'b0)};
            if (is_rd && (cnt == CNT_W'(1))) rd_data <= {shreg[BYTE_W-2:0], sda_in};
            cnt   <= cnt - CNT_W'(1);
            state <= ST_BIT_LO;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed self-checking bench for i2c_master_ctrl with an open-drain
// bus model (master and slave pull-downs wired together).
module tb_i2c_master_ctrl;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_tick;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic [7:0] wr_data;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic       ack_rcvd;
  logic       done;
  logic       err;
  logic       bus_owned;
  logic       scl_oe;
  logic       sda_oe;
  logic       scl_in;
  logic       sda_in;
  logic       slave_sda_low;
  logic       slave_scl_low;

  int total = 0;
  int bad   = 0;

  assign sda_in = ~(sda_oe | slave_sda_low);
  assign scl_in = ~(scl_oe | slave_scl_low);

  always #5 clk = ~clk;

  i2c_master_ctrl #(.BYTE_W(8)) dut (
    .clk(clk), .rst(rst), .scl_tick(scl_tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .wr_data(wr_data), .rd_ack(rd_ack), .rd_data(rd_data),
    .ack_rcvd(ack_rcvd), .done(done), .err(err), .bus_owned(bus_owned),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One-clk tick; returns at the negedge after the capturing posedge
  task automatic do_tick();
    @(negedge clk) scl_tick = 1'b1;
    @(negedge clk) scl_tick = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] c, input logic [7:0] d,
                          input logic a);
    @(negedge clk);
    cmd = c; wr_data = d; rd_ack = a; cmd_valid = 1'b1;
    @(negedge clk) cmd_valid = 1'b0;
  endtask

  logic wbits [8];
  logic rbits [8];
  logic e;

  initial begin
    wbits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};  // 0xA5
    rbits = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};  // 0x3C
    rst = 1'b1; scl_tick = 1'b0; cmd_valid = 1'b0; cmd = 2'd0;
    wr_data = 8'h00; rd_ack = 1'b0; slave_sda_low = 1'b0; slave_scl_low = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_scl_oe", scl_oe, 0);
    check_val("rst_sda_oe", sda_oe, 0);
    check_val("rst_owned", bus_owned, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ready", cmd_ready, 1);
    check_val("rst_rd_data", rd_data, 0);
    check_val("rst_ack", ack_rcvd, 0);
    rst = 1'b0;

    // START from IDLE
    send_cmd(I2C_CMD_START, 8'h00, 1'b0);
    check_val("st_pre_sda", sda_oe, 0);
    check_val("st_busy", cmd_ready, 0);
    do_tick();
    check_val("st_t1_sda", sda_oe, 1);
    check_val("st_t1_scl", scl_oe, 0);
    check_val("st_t1_done", done, 0);
    do_tick();
    check_val("st_t2_scl", scl_oe, 1);
    check_val("st_t2_owned", bus_owned, 1);
    check_val("st_t2_done", done, 1);
    check_val("st_t2_ready", cmd_ready, 1);

    // WRITE 0xA5, slave ACKs
    send_cmd(I2C_CMD_WRITE, 8'hA5, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i == 8) slave_sda_low = 1'b1;
      do_tick();
      check_val("wr_rise_scl", scl_oe, 0);
      if (i < 8) check_val("wr_bit", sda_in, wbits[i]);
      else       check_val("wr_ack_rel", sda_oe, 0);
      check_val("wr_no_done", done, 0);
      do_tick();
      check_val("wr_fall_scl", scl_oe, 1);
      if (i < 8) begin
        e = ~wbits[i];
        check_val("wr_sda_hold", sda_oe, e);
      end
    end
    check_val("wr_done", done, 1);
    check_val("wr_err", err, 0);
    check_val("wr_ack_rcvd", ack_rcvd, 1);
    slave_sda_low = 1'b0;
    @(negedge clk);
    check_val("wr_sda_release", sda_oe, 0);
    check_val("wr_done_pulse", done, 0);

    // READ with NACK, slave sends 0x3C
    send_cmd(I2C_CMD_READ, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) slave_sda_low = ~rbits[i];
      else       slave_sda_low = 1'b0;
      do_tick();
      check_val("rd_master_sda", sda_oe, 0);
      do_tick();
    end
    check_val("rd_done", done, 1);
    check_val("rd_data", rd_data, 8'h3C);
    check_val("rd_ack_hold", ack_rcvd, 1);

    // Repeated START
    send_cmd(I2C_CMD_START, 8'h00, 1'b0);
    do_tick();
    check_val("rs_t1_sda", sda_oe, 0);
    check_val("rs_t1_scl", scl_oe, 1);
    do_tick();
    check_val("rs_t2_scl", scl_oe, 0);
    check_val("rs_t2_sda", sda_oe, 0);
    do_tick();
    check_val("rs_t3_sda", sda_oe, 1);
    check_val("rs_t3_scl", scl_oe, 0);
    do_tick();
    check_val("rs_t4_scl", scl_oe, 1);
    check_val("rs_t4_done", done, 1);

    // STOP
    send_cmd(I2C_CMD_STOP, 8'h00, 1'b0);
    check_val("sp_sda", sda_oe, 1);
    do_tick();
    check_val("sp_t1_scl", scl_oe, 0);
    check_val("sp_t1_owned", bus_owned, 1);
    do_tick();
    check_val("sp_t2_sda", sda_oe, 0);
    check_val("sp_t2_owned", bus_owned, 0);
    check_val("sp_t2_done", done, 1);
    check_val("sp_t2_ready", cmd_ready, 1);

    // Illegal WRITE while bus not owned
    send_cmd(I2C_CMD_WRITE, 8'h55, 1'b0);
    check_val("il_done", done, 1);
    check_val("il_err", err, 1);
    check_val("il_scl", scl_oe, 0);
    check_val("il_sda", sda_oe, 0);
    do_tick();
    check_val("il_done_clr", done, 0);
    check_val("il_sda_still", sda_oe, 0);
    check_val("il_ready", cmd_ready, 1);

    // Reset in the middle of a WRITE
    send_cmd(I2C_CMD_START, 8'h00, 1'b0);
    do_tick();
    do_tick();
    send_cmd(I2C_CMD_WRITE, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) do_tick();
    check_val("mr_pre_sda", sda_oe, 1);
    rst = 1'b1;
    #1;
    check_val("mr_scl", scl_oe, 0);
    check_val("mr_sda", sda_oe, 0);
    check_val("mr_owned", bus_owned, 0);
    check_val("mr_ack", ack_rcvd, 0);
    check_val("mr_rd_data", rd_data, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("mr_no_done", done, 0);
    end
    rst = 1'b0;
    send_cmd(I2C_CMD_START, 8'h00, 1'b0);
    do_tick();
    check_val("mr_st_t1_sda", sda_oe, 1);
    do_tick();
    check_val("mr_st_owned", bus_owned, 1);
    check_val("mr_st_done", done, 1);

`ifdef I2C_CLK_STRETCH_EN
    // Slave stretches the SCL-high phase of the first cell
    send_cmd(I2C_CMD_WRITE, 8'hFF, 1'b0);
    do_tick();
    check_val("cs_rise", scl_oe, 0);
    slave_scl_low = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_tick();
      check_val("cs_held", scl_oe, 0);
    end
    slave_scl_low = 1'b0;
    do_tick();
    check_val("cs_fall", scl_oe, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
